// File: rtl/softmax_axis_pkg.sv
// Shared types and constants for the softmax S2MM stream arbiter.
package softmax_axis_pkg;

  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic PORT_SMAX = 1'b0;
  localparam logic PORT_PASS = 1'b1;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; a new load takes priority over a drain.
module axis_out_reg #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              id_i,
  input  logic              m_tready_i,
  output logic              m_tvalid_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tlast_o,
  output logic              m_tid_o
);

  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              tid_q, tid_d;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tid_d    = tid_q;
    if (load_i) begin
      tvalid_d = 1'b1;
      tdata_d  = data_i;
      tlast_d  = last_i;
      tid_d    = id_i;
    end else if (tvalid_q && m_tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tid_q    <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tid_q    <= tid_d;
    end
  end

  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o  = tdata_q;
  assign m_tlast_o  = tlast_q;
  assign m_tid_o    = tid_q;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing the S2MM stream between the
// softmax result path (port 0) and the pass-through path (port 1).
module axis_pkt_arbiter
  import softmax_axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_s2mm_tdata,
  output logic              m_axis_s2mm_tvalid,
  output logic              m_axis_s2mm_tlast,
  output logic              m_axis_s2mm_tid,
  input  logic              m_axis_s2mm_tready,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              out_free;
  logic              acc;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              sel_id;

  // Gating with rstn keeps both readies low while reset is held, even
  // before the first reset edge has cleared the state register.
  assign out_free       = !m_axis_s2mm_tvalid || m_axis_s2mm_tready;
  assign s0_axis_tready = rstn && (state_q == GNT0) && out_free;
  assign s1_axis_tready = rstn && (state_q == GNT1) && out_free;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    acc      = 1'b0;
    sel_data = s0_axis_tdata;
    sel_last = s0_axis_tlast;
    sel_id   = PORT_SMAX;
    unique case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_d = (last_q == PORT_SMAX) ? GNT1 : GNT0;
        end else if (s0_axis_tvalid) begin
          state_d = GNT0;
        end else if (s1_axis_tvalid) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        acc = s0_axis_tvalid && s0_axis_tready;
        if (acc && s0_axis_tlast) begin
          state_d = IDLE;
          last_d  = PORT_SMAX;
          cnt0_d  = cnt0_q + 1'b1;
        end
      end
      GNT1: begin
        sel_data = s1_axis_tdata;
        sel_last = s1_axis_tlast;
        sel_id   = PORT_PASS;
        acc      = s1_axis_tvalid && s1_axis_tready;
        if (acc && s1_axis_tlast) begin
          state_d = IDLE;
          last_d  = PORT_PASS;
          cnt1_d  = cnt1_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= PORT_PASS;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  axis_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (acc),
    .data_i    (sel_data),
    .last_i    (sel_last),
    .id_i      (sel_id),
    .m_tready_i(m_axis_s2mm_tready),
    .m_tvalid_o(m_axis_s2mm_tvalid),
    .m_tdata_o (m_axis_s2mm_tdata),
    .m_tlast_o (m_axis_s2mm_tlast),
    .m_tid_o   (m_axis_s2mm_tid)
  );

  assign busy     = (state_q != IDLE);
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench: directed timing scenarios plus randomized traffic
// checked against per-port beat queues and packet-level arbitration rules.
module tb_axis_pkt_arbiter;

  localparam int DW     = 128;
  localparam int TB_CNT = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s0_d = '0, s1_d = '0;
  logic          s0_v = 1'b0, s1_v = 1'b0, s0_l = 1'b0, s1_l = 1'b0;
  logic          s0_tready, s1_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tid;
  logic          m_rdy = 1'b1;
  logic          busy;
  logic [TB_CNT-1:0] pkt_cnt0, pkt_cnt1;

  axis_pkt_arbiter #(
    .DATA_W(DW),
    .CNT_W (TB_CNT)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .s0_axis_tdata     (s0_d),
    .s0_axis_tvalid    (s0_v),
    .s0_axis_tlast     (s0_l),
    .s0_axis_tready    (s0_tready),
    .s1_axis_tdata     (s1_d),
    .s1_axis_tvalid    (s1_v),
    .s1_axis_tlast     (s1_l),
    .s1_axis_tready    (s1_tready),
    .m_axis_s2mm_tdata (m_tdata),
    .m_axis_s2mm_tvalid(m_tvalid),
    .m_axis_s2mm_tlast (m_tlast),
    .m_axis_s2mm_tid   (m_tid),
    .m_axis_s2mm_tready(m_rdy),
    .busy              (busy),
    .pkt_cnt0          (pkt_cnt0),
    .pkt_cnt1          (pkt_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { int cyc; logic tid; logic [DW-1:0] d; logic l; } obs_t;

  beat_t exp0[$], exp1[$];
  obs_t  obs[$];
  int    model_cnt[2];
  int    model_last = 1;
  logic  in_pkt = 1'b0, cur_tid = 1'b0;
  int    n_tests = 0, n_fail = 0;
  bit    rand_done;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int p, input logic [DW-1:0] d, input logic l);
    bit done = 0;
    int n = 0;
    if (p == 0) begin s0_v = 1'b1; s0_d = d; s0_l = l; end
    else        begin s1_v = 1'b1; s1_d = d; s1_l = l; end
    while (!done && n < 500) begin
      @(negedge clk);
      done = (p == 0) ? (s0_tready === 1'b1) : (s1_tready === 1'b1);
      if (done) begin
        if (p == 0) exp0.push_back('{d, l}); else exp1.push_back('{d, l});
        if (l) begin model_cnt[p]++; model_last = p; end
      end
      step();
      n++;
    end
    if (!done) check_eq("tx_timeout", {127'b0, done}, 1);
    if (p == 0) s0_v = 1'b0; else s1_v = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int len, input logic [DW-1:0] base, input int gap_max);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(gap_max, 0)) step();
      send_beat(p, base + DW'(i), (i == len - 1));
    end
    check_eq("busy_after_last", {127'b0, busy}, 0);
    check_eq((p == 0) ? "pkt_cnt0" : "pkt_cnt1",
             DW'((p == 0) ? pkt_cnt0 : pkt_cnt1),
             DW'(model_cnt[p] % (1 << TB_CNT)));
  endtask

  task automatic flush_model();
    exp0.delete();
    exp1.delete();
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    model_last = 1;
    in_pkt = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s0_v = 1'b1;
    s1_v = 1'b1;
    step();
    step();
    @(negedge clk);
    check_eq("rst_tvalid", {127'b0, m_tvalid}, 0);
    check_eq("rst_tdata", m_tdata, 0);
    check_eq("rst_tlast", {127'b0, m_tlast}, 0);
    check_eq("rst_tid", {127'b0, m_tid}, 0);
    check_eq("rst_busy", {127'b0, busy}, 0);
    check_eq("rst_rdy", {126'b0, s0_tready, s1_tready}, 0);
    check_eq("rst_cnt", {120'b0, pkt_cnt0, pkt_cnt1}, 0);
    flush_model();
    s0_v = 1'b0;
    s1_v = 1'b0;
    rstn = 1'b1;
    step();
  endtask

  // Output monitor: scoreboard against per-port queues, interleave and single-grant rules.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        check_eq("one_grant", {127'b0, s0_tready & s1_tready}, 0);
        if (m_tvalid && m_rdy) begin
          obs.push_back('{cyc, m_tid, m_tdata, m_tlast});
          if (in_pkt) check_eq("no_interleave", {127'b0, m_tid}, {127'b0, cur_tid});
          if (m_tid == 1'b0) begin
            check_eq("sb_has0", {127'b0, exp0.size() != 0}, 1);
            if (exp0.size() != 0) begin
              e = exp0.pop_front();
              check_eq("sb_data0", m_tdata, e.d);
              check_eq("sb_last0", {127'b0, m_tlast}, {127'b0, e.l});
            end
          end else begin
            check_eq("sb_has1", {127'b0, exp1.size() != 0}, 1);
            if (exp1.size() != 0) begin
              e = exp1.pop_front();
              check_eq("sb_data1", m_tdata, e.d);
              check_eq("sb_last1", {127'b0, m_tlast}, {127'b0, e.l});
            end
          end
          in_pkt  = !m_tlast;
          cur_tid = m_tid;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, pk, exp_first;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    do_reset();

    // Single 4-beat packet: data 1..4 appears in cycles start+2 .. start+5.
    obs.delete();
    t0 = cyc;
    send_pkt(0, 4, 1, 0);
    repeat (3) step();
    check_eq("A_nbeats", DW'(obs.size()), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      check_eq("A_cycle", DW'(obs[i].cyc), DW'(t0 + 2 + i));
      check_eq("A_data", obs[i].d, DW'(i + 1));
      check_eq("A_tid", {127'b0, obs[i].tid}, 0);
      check_eq("A_last", {127'b0, obs[i].l}, {127'b0, i == 3});
    end

    // Contention: alternating order starting with the port not granted last, one bubble between.
    obs.delete();
    exp_first = 1 - model_last;
    fork
      begin for (int k = 0; k < 3; k++) send_pkt(0, 2, DW'('h100 + 16 * k), 0); end
      begin for (int k = 0; k < 3; k++) send_pkt(1, 2, DW'('h200 + 16 * k), 0); end
    join
    repeat (3) step();
    check_eq("C_nbeats", DW'(obs.size()), 12);
    pk = 0;
    for (int i = 0; i < obs.size(); i++) begin
      if (i > 0 && obs[i-1].l) begin
        pk++;
        check_eq("C_bubble", DW'(obs[i].cyc - obs[i-1].cyc), 2);
      end else if (i > 0) begin
        check_eq("C_back2back", DW'(obs[i].cyc - obs[i-1].cyc), 1);
      end
      check_eq("C_order", {127'b0, obs[i].tid}, DW'((exp_first + pk) % 2));
    end

    // Backpressure while beat 2 sits in the output register.
    fork
      send_pkt(0, 4, 'h11, 0);
      begin
        repeat (3) step();
        m_rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("B_hold_data", m_tdata, 'h12);
          check_eq("B_hold_valid", {127'b0, m_tvalid}, 1);
          check_eq("B_s0_rdy", {127'b0, s0_tready}, 0);
          step();
        end
        m_rdy = 1'b1;
      end
    join
    repeat (3) step();
    check_eq("B_drained", DW'(exp0.size()), 0);

    // Back-to-back single-beat packets from port 1: one beat every 2 cycles.
    obs.delete();
    for (int k = 0; k < 4; k++) send_pkt(1, 1, DW'('h300 + k), 0);
    repeat (3) step();
    check_eq("S_nbeats", DW'(obs.size()), 4);
    for (int i = 0; i < obs.size(); i++) begin
      check_eq("S_tid", {127'b0, obs[i].tid}, 1);
      check_eq("S_last", {127'b0, obs[i].l}, 1);
      if (i > 0) check_eq("S_spacing", DW'(obs[i].cyc - obs[i-1].cyc), 2);
    end

    // Reset after beat 2 of 4, then a fresh packet must arrive intact.
    send_beat(0, 'h400, 1'b0);
    send_beat(0, 'h401, 1'b0);
    rstn = 1'b0;
    s0_v = 1'b1;
    step();
    @(negedge clk);
    check_eq("R_tvalid", {127'b0, m_tvalid}, 0);
    check_eq("R_tdata", m_tdata, 0);
    check_eq("R_busy", {127'b0, busy}, 0);
    check_eq("R_s0_rdy", {127'b0, s0_tready}, 0);
    check_eq("R_cnt0", DW'(pkt_cnt0), 0);
    flush_model();
    s0_v = 1'b0;
    rstn = 1'b1;
    step();
    send_pkt(0, 4, 'h500, 0);
    repeat (4) step();
    check_eq("R_delivered", DW'(exp0.size()), 0);

    // Counter wrap: 17 packets on a 4-bit counter.
    do_reset();
    for (int k = 0; k < 17; k++) send_pkt(0, 1, DW'('h600 + k), 0);
    check_eq("W_wrap", DW'(pkt_cnt0), 1);

    // Randomized traffic with mid-packet gaps and random downstream stalls.
    rand_done = 0;
    fork
      begin
        fork
          begin for (int k = 0; k < 25; k++) send_pkt(0, $urandom_range(5, 1), {$urandom, $urandom, $urandom, $urandom}, 2); end
          begin for (int k = 0; k < 25; k++) send_pkt(1, $urandom_range(5, 1), {$urandom, $urandom, $urandom, $urandom}, 2); end
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          m_rdy = ($urandom_range(99, 0) < 70);
          step();
        end
        m_rdy = 1'b1;
      end
    join
    repeat (5) step();
    check_eq("X_drained0", DW'(exp0.size()), 0);
    check_eq("X_drained1", DW'(exp1.size()), 0);
    check_eq("X_idle", {127'b0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
